csi2tx_mux_sync_rx: RTL and testbench

Multi-channel, destination-side, mux-based data synchronizer for the CSI-2 TX configuration and status paths. The block runs entirely in the destination clock domain. Each channel receives a request toggle from a foreign domain, passes it through a parametrised synchronizer chain and detects its edge. On an edge it captures that channel's quasi-static data bus, returns an acknowledge toggle, and tracks valid, overrun and drop state per channel. It supersedes single-channel pulse-enabled capture with configurable width, channel count and sync depth, a return handshake, and consumer flow-control flags.

---
 rtl/csi2tx_mux_sync_rx.sv | 71 +++++++
 tb/tb_csi2tx_mux_sync_rx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/csi2tx_mux_sync_rx.sv
// csi2tx_mux_sync_rx: multi-channel toggle-handshake data synchronizer, destination side.
// Each channel syncs its request toggle, captures its data bus on an edge and returns an ack toggle.
module csi2tx_mux_sync_rx #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_CH      = 4,
   parameter int                    SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
   input  logic                         clk_dest,
   input  logic                         rstb_n,
   input  logic [NUM_CH-1:0]            req_tgl,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]            ch_en,
   input  logic [NUM_CH-1:0]            rd_ack,
   input  logic [NUM_CH-1:0]            ovr_clr,
   output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
   output logic [NUM_CH-1:0]            out_valid,
   output logic [NUM_CH-1:0]            upd_pulse,
   output logic [NUM_CH-1:0]            ack_tgl,
   output logic [NUM_CH-1:0]            overrun,
   output logic [NUM_CH-1:0]            drop
);
   logic [NUM_CH-1:0][SYNC_STAGES-1:0] sync_q;
   logic [NUM_CH-1:0]                  sync_last, prev_q, evt, cap, drp;
   logic [NUM_CH-1:0]                  valid_q, valid_d, upd_q, ack_q, ovr_q, ovr_d, drop_q, drop_d;
   logic [NUM_CH*DATA_WIDTH-1:0]       data_q, data_d;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) sync_last[c] = sync_q[c][SYNC_STAGES-1];
      evt     = sync_last ^ prev_q;
      cap     = evt & ch_en;
      drp     = evt & ~ch_en;
      valid_d = cap | (valid_q & ~rd_ack);
      // a same-cycle rd_ack consumed the old data, so that capture is not an overrun
      ovr_d   = (cap & valid_q & ~rd_ack) | (ovr_q & ~ovr_clr);
      drop_d  = drp | (drop_q & ~ovr_clr);
      data_d  = data_q;
      for (int c = 0; c < NUM_CH; c++)
         if (cap[c]) data_d[c*DATA_WIDTH +: DATA_WIDTH] = in_data[c*DATA_WIDTH +: DATA_WIDTH];
   end

   always_ff @(posedge clk_dest) begin
      if (!rstb_n) begin
         sync_q  <= '0;
         prev_q  <= '0;
         data_q  <= {NUM_CH{INIT_VALUE}};
         valid_q <= '0;
         upd_q   <= '0;
         ack_q   <= '0;
         ovr_q   <= '0;
         drop_q  <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], req_tgl[c]};
         prev_q  <= sync_last;
         data_q  <= data_d;
         valid_q <= valid_d;
         upd_q   <= cap;
         // ack returns even for dropped requests so the source never stalls
         ack_q   <= ack_q ^ evt;
         ovr_q   <= ovr_d;
         drop_q  <= drop_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign upd_pulse = upd_q;
   assign ack_tgl   = ack_q;
   assign overrun   = ovr_q;
   assign drop      = drop_q;
endmodule

// File: tb/tb_csi2tx_mux_sync_rx.sv
// tb_csi2tx_mux_sync_rx: directed and random checks of two synchronizer instances (2 and 4 stages)
// against a sample-history reference model.
module tb_csi2tx_mux_sync_rx;
   localparam int          W    = 32;
   localparam int          N    = 4;
   localparam logic [31:0] INIT = 32'hA5A5_0000;

   logic           clk = 0, rstb_n = 0;
   logic [N-1:0]   req = '0, en = '1, rda = '0, oc = '0;
   logic [N*W-1:0] din = '0;
   logic [N*W-1:0] od [2];
   logic [N-1:0]   ov [2], up [2], ak [2], orr [2], dr [2];

   always #5 clk = ~clk;

   csi2tx_mux_sync_rx #(.DATA_WIDTH(W), .NUM_CH(N), .SYNC_STAGES(2), .INIT_VALUE(INIT)) u0 (
      .clk_dest(clk), .rstb_n(rstb_n), .req_tgl(req), .in_data(din), .ch_en(en), .rd_ack(rda),
      .ovr_clr(oc), .out_data(od[0]), .out_valid(ov[0]), .upd_pulse(up[0]), .ack_tgl(ak[0]),
      .overrun(orr[0]), .drop(dr[0]));
   csi2tx_mux_sync_rx #(.DATA_WIDTH(W), .NUM_CH(N), .SYNC_STAGES(4), .INIT_VALUE(INIT)) u1 (
      .clk_dest(clk), .rstb_n(rstb_n), .req_tgl(req), .in_data(din), .ch_en(en), .rd_ack(rda),
      .ovr_clr(oc), .out_data(od[1]), .out_valid(ov[1]), .upd_pulse(up[1]), .ack_tgl(ak[1]),
      .overrun(orr[1]), .drop(dr[1]));

   int vectors = 0, miscompares = 0;

   // h[k] is the request value sampled k edges ago since the last reset
   logic [N-1:0]   h [$];
   logic [N*W-1:0] md [2];
   logic [N-1:0]   mv [2], mu [2], ma [2], mo [2], mp [2];

   task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] seen(input int k);
      return (h.size() > k) ? h[k] : '0;
   endfunction

   task automatic model_edge();
      if (!rstb_n) begin
         h.delete();
         for (int d = 0; d < 2; d++) begin
            md[d] = {N{INIT}};
            mv[d] = '0; mu[d] = '0; ma[d] = '0; mo[d] = '0; mp[d] = '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            int s = d ? 4 : 2;
            // a toggle is seen when the value synced s edges ago differs from one edge earlier
            logic [N-1:0] ev = seen(s - 1) ^ seen(s);
            for (int c = 0; c < N; c++) begin
               logic capt = ev[c] & en[c];
               mu[d][c] = capt;
               if (ev[c]) ma[d][c] = ~ma[d][c];
               if (oc[c]) begin mo[d][c] = 0; mp[d][c] = 0; end
               if (ev[c] && !en[c]) mp[d][c] = 1;
               if (capt && mv[d][c] && !rda[c]) mo[d][c] = 1;
               if (capt) begin
                  md[d][c*W +: W] = din[c*W +: W];
                  mv[d][c] = 1;
               end else if (rda[c]) mv[d][c] = 0;
            end
         end
         h.push_front(req);
         if (h.size() > 8) void'(h.pop_back());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d_data", d), od[d], md[d]);
         check($sformatf("d%0d_valid", d), {{(N*W-N){1'b0}}, ov[d]}, {{(N*W-N){1'b0}}, mv[d]});
         check($sformatf("d%0d_upd", d), {{(N*W-N){1'b0}}, up[d]}, {{(N*W-N){1'b0}}, mu[d]});
         check($sformatf("d%0d_ack", d), {{(N*W-N){1'b0}}, ak[d]}, {{(N*W-N){1'b0}}, ma[d]});
         check($sformatf("d%0d_ovr", d), {{(N*W-N){1'b0}}, orr[d]}, {{(N*W-N){1'b0}}, mo[d]});
         check($sformatf("d%0d_drop", d), {{(N*W-N){1'b0}}, dr[d]}, {{(N*W-N){1'b0}}, mp[d]});
      end
   endtask

   task automatic flip(input int c, input logic [W-1:0] v);
      din[c*W +: W] = v;
      req[c] = ~req[c];
   endtask

   task automatic settle();
      repeat (6) tick();
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         md[d] = {N{INIT}}; mv[d] = '0; mu[d] = '0; ma[d] = '0; mo[d] = '0; mp[d] = '0;
      end
      // reset held while inputs wiggle
      for (int i = 0; i < 4; i++) begin
         req = N'($urandom); din = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      check("rst_data", od[0], {N{INIT}});
      check("rst_ack", {{(N*W-N){1'b0}}, ak[1]}, '0);
      req = '0; rstb_n = 1;
      tick(); tick();
      // basic capture latency
      flip(1, 32'hDEAD_BEEF);
      tick(); tick();
      check("basic_upd_early", {{(N*W-N){1'b0}}, up[0]}, '0);
      tick();
      check("basic_upd", {{(N*W-N){1'b0}}, up[0]}, {{(N*W-N){1'b0}}, 4'b0010});
      check("basic_data", {{(N*W-W){1'b0}}, od[0][W +: W]}, {{(N*W-W){1'b0}}, 32'hDEAD_BEEF});
      tick();
      check("basic_upd_once", {{(N*W-N){1'b0}}, up[0]}, '0);
      tick();
      check("s4_upd", {{(N*W-N){1'b0}}, up[1]}, {{(N*W-N){1'b0}}, 4'b0010});
      settle();
      // overrun then clear
      flip(0, 32'd1); settle();
      flip(0, 32'd2); settle();
      check("ovr_set", {{(N*W-N){1'b0}}, orr[0][0]}, 1);
      check("ovr_data", {{(N*W-W){1'b0}}, od[0][0 +: W]}, 2);
      oc[0] = 1; tick(); oc[0] = 0;
      check("ovr_clr", {{(N*W-N){1'b0}}, orr[0][0]}, 0);
      rda[0] = 1; tick(); rda[0] = 0;
      flip(0, 32'd3); settle();
      flip(0, 32'd4); tick(); tick();
      rda[0] = 1; tick(); rda[0] = 0;
      settle();
      check("ack_cap_ovr", {{(N*W-N){1'b0}}, orr[0][0]}, 0);
      check("ack_cap_valid", {{(N*W-N){1'b0}}, ov[0][0]}, 1);
      // disabled channel
      en[2] = 0; flip(2, 32'h1234_5678); settle();
      check("dis_drop", {{(N*W-N){1'b0}}, dr[0][2]}, 1);
      check("dis_ack", {{(N*W-N){1'b0}}, ak[1][2]}, 1);
      en[2] = 1; settle();
      check("dis_valid", {{(N*W-N){1'b0}}, ov[1][2]}, 0);
      // all channels simultaneously
      for (int c = 0; c < N; c++) flip(c, 32'hC0DE_0000 + 32'(c));
      tick(); tick(); tick();
      check("all_upd", {{(N*W-N){1'b0}}, up[0]}, {{(N*W-N){1'b0}}, 4'hF});
      settle();
      // reset while an edge is in flight
      flip(3, 32'hBAD0_BAD0); tick();
      rstb_n = 0; req = '0; tick();
      rstb_n = 1; settle();
      check("mid_rst_ack", {{(N*W-N){1'b0}}, ak[0][3]}, 0);
      check("mid_rst_data", {{(N*W-W){1'b0}}, od[0][3*W +: W]}, {{(N*W-W){1'b0}}, INIT});
      // random traffic under handshake flow control
      for (int i = 0; i < 600; i++) begin
         if (!rstb_n) begin rstb_n = 1; req = '0; end
         else if ($urandom_range(0, 99) == 0) begin rstb_n = 0; req = '0; end
         en  = N'($urandom) | N'($urandom);
         rda = N'($urandom) & N'($urandom);
         oc  = N'($urandom) & N'($urandom) & N'($urandom);
         if (rstb_n)
            for (int c = 0; c < N; c++)
               if (req[c] == ma[0][c] && req[c] == ma[1][c] && $urandom_range(0, 2) == 0)
                  flip(c, $urandom);
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
